// File: rtl/bcd_frame_sequencer.sv
// bcd_frame_sequencer: hunts a serial link for a sync byte, captures an
// op bit plus two BCD operands, validates them and runs a digit-serial
// BCD add/sub (least significant digit first). Results leave on a
// valid/ready handshake.
module bcd_frame_sequencer #(
    parameter logic [7:0]  SYNC_PATTERN = 8'h5A,
    parameter int unsigned DIGITS       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  din,
    input  logic                  din_valid,
    output logic [4*DIGITS-1:0]   result,
    output logic                  result_cout,
    output logic                  result_op,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = $clog2(W);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [2:0] {
        S_HUNT,
        S_OP,
        S_OPA,
        S_OPB,
        S_CHECK,
        S_EXEC,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [7:0]      r_hunt_sr;
    logic [CW-1:0]   r_bit_cnt;
    logic            r_op;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_acc;
    logic [IW-1:0]   r_idx;
    logic            r_carry;

    logic [7:0]      w_hunt_win;
    logic            w_sync_hit;
    logic            w_bits_last;
    logic            w_exec_last;
    logic            w_bad_digit;
    logic [3:0]      w_a_dig;
    logic [3:0]      w_b_dig;
    logic [4:0]      w_sum;
    logic [3:0]      w_dig;
    logic            w_carry_next;
    logic [W-1:0]    w_acc_next;

    assign w_hunt_win  = {r_hunt_sr[6:0], din};
    assign w_sync_hit  = din_valid && (w_hunt_win == SYNC_PATTERN);
    assign w_bits_last = (r_bit_cnt == CW'(W - 1));
    assign w_exec_last = (r_idx == IW'(DIGITS - 1));
    assign busy        = (r_state != S_HUNT);

    // Flag any operand nibble outside 0..9.
    always_comb begin
        w_bad_digit = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if ((r_a[4*i +: 4] > 4'd9) || (r_b[4*i +: 4] > 4'd9)) begin
                w_bad_digit = 1'b1;
            end
        end
    end

    // One-digit BCD add/sub on the digit selected by r_idx.
    always_comb begin
        w_a_dig      = r_a[r_idx*4 +: 4];
        w_b_dig      = r_b[r_idx*4 +: 4];
        w_sum        = '0;
        w_dig        = '0;
        w_carry_next = 1'b0;
        if (!r_op) begin
            w_sum = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {4'd0, r_carry};
            if (w_sum > 5'd9) begin
                w_dig        = w_sum[3:0] + 4'd6;
                w_carry_next = 1'b1;
            end else begin
                w_dig        = w_sum[3:0];
            end
        end else begin
            w_sum = {1'b0, w_a_dig} - {1'b0, w_b_dig} - {4'd0, r_carry};
            if (w_sum[4]) begin
                w_dig        = w_sum[3:0] + 4'd10;
                w_carry_next = 1'b1;
            end else begin
                w_dig        = w_sum[3:0];
            end
        end
        w_acc_next = r_acc;
        w_acc_next[r_idx*4 +: 4] = w_dig;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; receive states hold across din_valid gaps.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_HUNT:  if (w_sync_hit) w_state_next = S_OP;
            S_OP:    if (din_valid) w_state_next = S_OPA;
            S_OPA:   if (din_valid && w_bits_last) w_state_next = S_OPB;
            S_OPB:   if (din_valid && w_bits_last) w_state_next = S_CHECK;
            S_CHECK: w_state_next = w_bad_digit ? S_HUNT : S_EXEC;
            S_EXEC:  if (w_exec_last) w_state_next = S_DONE;
            S_DONE:  if (result_ready) w_state_next = S_HUNT;
            default: w_state_next = S_HUNT;
        endcase
    end

    // Datapath: hunting, operand capture, digit iteration and outputs.
    // The hunt register is held at zero outside HUNT, so every return to
    // HUNT starts from a cleared register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hunt_sr    <= '0;
            r_bit_cnt    <= '0;
            r_op         <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            r_idx        <= '0;
            r_carry      <= 1'b0;
            result       <= '0;
            result_cout  <= 1'b0;
            result_op    <= 1'b0;
            result_valid <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (r_state != S_HUNT) begin
                r_hunt_sr <= '0;
            end
            case (r_state)
                S_HUNT: begin
                    if (din_valid) begin
                        r_hunt_sr <= w_sync_hit ? 8'h00 : w_hunt_win;
                    end
                end
                S_OP: begin
                    if (din_valid) begin
                        r_op      <= din;
                        r_bit_cnt <= '0;
                    end
                end
                S_OPA: begin
                    if (din_valid) begin
                        r_a       <= {r_a[W-2:0], din};
                        r_bit_cnt <= w_bits_last ? '0 : r_bit_cnt + 1'b1;
                    end
                end
                S_OPB: begin
                    if (din_valid) begin
                        r_b       <= {r_b[W-2:0], din};
                        r_bit_cnt <= w_bits_last ? '0 : r_bit_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    overrun   <= din_valid;
                    frame_err <= w_bad_digit;
                    r_idx     <= '0;
                    r_carry   <= 1'b0;
                end
                S_EXEC: begin
                    overrun <= din_valid;
                    r_acc   <= w_acc_next;
                    r_carry <= w_carry_next;
                    if (w_exec_last) begin
                        r_idx        <= '0;
                        result       <= w_acc_next;
                        result_cout  <= w_carry_next;
                        result_op    <= r_op;
                        result_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    overrun <= din_valid;
                    if (result_ready) begin
                        result_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_frame_sequencer.sv
// Self-checking bench for bcd_frame_sequencer: directed frames plus
// randomized frames, checked against an arithmetic reference model that
// parses the transmitted bit stream.
module tb_bcd_frame_sequencer;

    localparam int D     = 4;
    localparam int W     = 4 * D;
    localparam int POW10 = 10000;

    logic         clk = 1'b0;
    logic         reset;
    logic         din;
    logic         din_valid;
    logic [W-1:0] result;
    logic         result_cout;
    logic         result_op;
    logic         result_valid;
    logic         result_ready;
    logic         frame_err;
    logic         overrun;
    logic         busy;

    int n_total = 0;
    int n_bad   = 0;

    bit s_q[$];

    bcd_frame_sequencer #(
        .SYNC_PATTERN (8'h5A),
        .DIGITS       (D)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .din          (din),
        .din_valid    (din_valid),
        .result       (result),
        .result_cout  (result_cout),
        .result_op    (result_op),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .frame_err    (frame_err),
        .overrun      (overrun),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic bit bcd_ok(input logic [W-1:0] v);
        logic [3:0] nib;
        for (int i = 0; i < D; i++) begin
            nib = v[4*i +: 4];
            if (nib > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int bcd2int(input logic [W-1:0] v);
        int acc = 0;
        for (int i = D - 1; i >= 0; i--) acc = acc * 10 + int'(v[4*i +: 4]);
        return acc;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        int t = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Locate the first sync match (hunter starts from zeros) and pull the
    // op bit and both operands out of the stream that follows it.
    task automatic model_parse(output bit found, output logic op,
                               output logic [W-1:0] a, output logic [W-1:0] b);
        logic [7:0] win = 8'h00;
        int lock = -1;
        found = 1'b0; op = 1'b0; a = '0; b = '0;
        for (int i = 0; i < s_q.size(); i++) begin
            win = {win[6:0], s_q[i]};
            if (win == 8'h5A) begin
                lock = i;
                break;
            end
        end
        if (lock >= 0 && lock + 1 + 2 * W < s_q.size() + 1) begin
            found = 1'b1;
            op = s_q[lock + 1];
            for (int i = 0; i < W; i++) a = {a[W-2:0], logic'(s_q[lock + 2 + i])};
            for (int i = 0; i < W; i++) b = {b[W-2:0], logic'(s_q[lock + 2 + W + i])};
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic push_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) s_q.push_back(v[i]);
    endtask

    task automatic build_frame(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
        s_q.delete();
        push_bits(32'h5A, 8);
        push_bits({31'd0, op}, 1);
        push_bits({16'd0, a}, W);
        push_bits({16'd0, b}, W);
    endtask

    // Shift the queued stream in, with random idle gaps; result_ready is
    // toggled randomly since it must be ignored while no result is pending.
    task automatic send_stream(input int gap_max);
        foreach (s_q[i]) begin
            repeat ($urandom_range(0, gap_max)) begin
                din_valid    = 1'b0;
                din          = 1'($urandom_range(0, 1));
                result_ready = 1'($urandom_range(0, 1));
                tick();
            end
            din_valid    = 1'b1;
            din          = s_q[i];
            result_ready = 1'($urandom_range(0, 1));
            tick();
        end
        din_valid    = 1'b0;
        result_ready = 1'b0;
    endtask

    // Called right after the edge that captured the last frame bit (E0).
    task automatic finish_frame(input int hold);
        bit           found;
        logic         op;
        logic [W-1:0] a, b, exp_res;
        logic         exp_cout;
        bit           exp_err;
        int           ia, ib, r;
        model_parse(found, op, a, b);
        exp_err = !(bcd_ok(a) && bcd_ok(b));
        ia = bcd2int(a);
        ib = bcd2int(b);
        if (!op) begin
            r        = ia + ib;
            exp_cout = (r >= POW10);
            exp_res  = int2bcd(r % POW10);
        end else begin
            r        = ia - ib;
            exp_cout = (r < 0);
            exp_res  = int2bcd((r + POW10) % POW10);
        end

        check_eq("busy_e0", busy, 1);
        check_eq("model_lock", found, 1);
        tick();                                   // E1
        check_eq("frame_err_e1", frame_err, exp_err);
        if (exp_err) begin
            tick();
            check_eq("frame_err_pulse", frame_err, 0);
            check_eq("err_busy", busy, 0);
            check_eq("err_no_valid", result_valid, 0);
            return;
        end
        tick(); tick(); tick();                   // E2..E4
        check_eq("valid_early", result_valid, 0);
        tick();                                   // E5
        check_eq("valid_e5", result_valid, 1);
        check_eq("result", result, exp_res);
        check_eq("result_cout", result_cout, exp_cout);
        check_eq("result_op", result_op, op);
        check_eq("overrun_idle", overrun, 0);

        for (int k = 0; k < hold; k++) begin
            logic dv;
            dv        = 1'($urandom_range(0, 1));
            din_valid = dv;
            din       = 1'($urandom_range(0, 1));
            tick();
            din_valid = 1'b0;
            check_eq("overrun_done", overrun, dv);
            check_eq("hold_valid", result_valid, 1);
            check_eq("hold_result", result, exp_res);
            check_eq("hold_busy", busy, 1);
        end
        if (hold > 0) begin
            tick();
            check_eq("overrun_clear", overrun, 0);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check_eq("hs_valid", result_valid, 0);
        check_eq("hs_busy", busy, 0);
        check_eq("hs_result_kept", result, exp_res);
    endtask

    task automatic run_frame(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                             input int gap_max, input int hold);
        build_frame(op, a, b);
        send_stream(gap_max);
        finish_frame(hold);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_result"}, result, 0);
        check_eq({tag, "_cout"}, result_cout, 0);
        check_eq({tag, "_op"}, result_op, 0);
        check_eq({tag, "_valid"}, result_valid, 0);
        check_eq({tag, "_ferr"}, frame_err, 0);
        check_eq({tag, "_ovr"}, overrun, 0);
        check_eq({tag, "_busy"}, busy, 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v;
        for (int i = 0; i < D; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] a, b, a5;
        reset        = 1'b0;
        din          = 1'b0;
        din_valid    = 1'b0;
        result_ready = 1'b0;
        repeat (3) tick();
        check_reset_outputs("rst");
        release_reset();

        // T1..T3: directed arithmetic
        run_frame(1'b0, 16'h1234, 16'h5678, 0, 0);
        run_frame(1'b0, 16'h9999, 16'h0001, 1, 2);
        run_frame(1'b1, 16'h0100, 16'h0001, 0, 0);
        run_frame(1'b1, 16'h0001, 16'h0002, 2, 1);
        run_frame(1'b1, 16'h4321, 16'h4321, 0, 0);

        // T4: bad digit, then a good frame
        run_frame(1'b0, 16'h12A4, 16'h1111, 0, 0);
        run_frame(1'b1, 16'h5000, 16'h1234, 0, 0);

        // T5: garbage 0x2D ahead of the sync byte; the hunter locks at the
        // first 0x5A window, so the tail is built to make that frame valid.
        a5 = {4'h6, 4'h8 | 4'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        b  = rand_bcd();
        s_q.delete();
        push_bits(32'h2D, 8);
        push_bits(32'h5A, 8);
        push_bits({22'd0, a5[9:0]}, 10);
        push_bits({16'd0, b}, W);
        send_stream(3);
        finish_frame(10);

        // Randomized frames, some with a corrupted nibble
        for (int n = 0; n < 25; n++) begin
            a = rand_bcd();
            b = rand_bcd();
            if ($urandom_range(0, 4) == 0) begin
                int p;
                p = $urandom_range(0, D - 1);
                if ($urandom_range(0, 1) == 0) a[4*p +: 4] = 4'($urandom_range(10, 15));
                else                           b[4*p +: 4] = 4'($urandom_range(10, 15));
            end
            run_frame(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 2), $urandom_range(0, 4));
        end

        // T6: reset mid-OPB
        run_frame(1'b0, 16'h1111, 16'h2222, 0, 0);
        s_q.delete();
        push_bits(32'h5A, 8);
        push_bits(32'h0, 1);
        push_bits(32'h4444, W);
        push_bits(32'h55, 8);
        send_stream(1);
        check_eq("mid_opb_busy", busy, 1);
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_opb");
        release_reset();

        // T6: reset mid-EXEC
        run_frame(1'b0, 16'h1111, 16'h2222, 0, 0);
        build_frame(1'b0, 16'h0909, 16'h0091);
        send_stream(0);
        tick(); tick();
        check_eq("mid_exec_busy", busy, 1);
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_exec");
        release_reset();
        run_frame(1'b0, 16'h0909, 16'h0091, 1, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
